kanagawa_logic_ram: RTL and testbench

Register-based (logic/LUT) RAM with one synchronous write port and NUM_READ_PORTS independent combinational read ports. It is used wherever a small, shallow memory must serve several simultaneous readers without block-RAM read latency. Depth need not be a power of two.

---
 rtl/kanagawa_logic_ram_pkg.sv | 9 +
 rtl/kanagawa_logic_ram_read_port.sv | 24 ++
 rtl/kanagawa_logic_ram.sv | 44 ++++
 tb/tb_kanagawa_logic_ram.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/kanagawa_logic_ram_pkg.sv
// Shared helpers for the kanagawa logic RAM slice.
// Address range checks are done in 32-bit arithmetic so any ADDR_WIDTH compares cleanly against DEPTH.
package kanagawa_logic_ram_pkg;

  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/kanagawa_logic_ram_read_port.sv
// One combinational read port: a DEPTH:1 mux over the flop array.
// Addresses outside 0..DEPTH-1 read as all zeros.
module kanagawa_logic_ram_read_port
  import kanagawa_logic_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 217
) (
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem,
  input  logic [ADDR_WIDTH-1:0]            rdaddr,
  output logic [DATA_WIDTH-1:0]            rddata
);

  always_comb begin
    rddata = '0;
    if (addr_in_range(32'(rdaddr), DEPTH)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rdaddr == ADDR_WIDTH'(i)) rddata = mem[i];
      end
    end
  end

endmodule

// File: rtl/kanagawa_logic_ram.sv
// Flop-based RAM: one synchronous write port, NUM_READ_PORTS zero-latency read ports.
// Storage is never cleared; rst only blocks writes.
module kanagawa_logic_ram
  import kanagawa_logic_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int DEPTH          = 217,
  parameter int NUM_READ_PORTS = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_READ_PORTS-1:0][ADDR_WIDTH-1:0] rdaddr_in,
  output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0] rddata_out,
  input  logic                                     wren_in,
  input  logic [ADDR_WIDTH-1:0]                    wraddr_in,
  input  logic [DATA_WIDTH-1:0]                    wrdata_in
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic                             wr_ok;

  assign wr_ok = wren_in && !rst && addr_in_range(32'(wraddr_in), DEPTH);

  // Reads see the pre-edge contents, so read-during-write returns old data.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && (wraddr_in == ADDR_WIDTH'(i))) mem[i] <= wrdata_in;
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    kanagawa_logic_ram_read_port #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DEPTH     (DEPTH)
    ) u_rd (
      .mem   (mem),
      .rdaddr(rdaddr_in[p]),
      .rddata(rddata_out[p])
    );
  end

endmodule

// File: tb/tb_kanagawa_logic_ram.sv
// Self-checking bench for kanagawa_logic_ram against an array-based reference model.
module tb_kanagawa_logic_ram;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 217;
  localparam int NP    = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NP-1:0][AW-1:0]  rdaddr_in;
  logic [NP-1:0][DW-1:0]  rddata_out;
  logic                   wren_in;
  logic [AW-1:0]          wraddr_in;
  logic [DW-1:0]          wrdata_in;

  kanagawa_logic_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NUM_READ_PORTS(NP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rdaddr_in (rdaddr_in),
    .rddata_out(rddata_out),
    .wren_in   (wren_in),
    .wraddr_in (wraddr_in),
    .wrdata_in (wrdata_in)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] model [DEPTH];
  int errors = 0;
  int checks = 0;

  typedef struct {
    string         name;
    logic [AW-1:0] a1, a0;
    logic [DW-1:0] e1, e0;
  } vec_t;
  vec_t vecs [4];

  function automatic logic [DW-1:0] model_read(input int addr);
    return (addr < DEPTH) ? model[addr] : '0;
  endfunction

  task automatic chk(input string name, input int port, input logic [DW-1:0] exp);
    checks++;
    if (rddata_out[port] !== exp) begin
      errors++;
      $display("FAIL %s port%0d addr=%0d got=%h exp=%h", name, port, rdaddr_in[port],
               rddata_out[port], exp);
    end
  endtask

  // Advance one edge; the model applies the write rules to what the DUT saw at that edge.
  task automatic tick();
    @(posedge clk);
    if (wren_in && !rst && int'(wraddr_in) < DEPTH) model[wraddr_in] = wrdata_in;
    #1;
  endtask

  task automatic wr(input int addr, input logic [DW-1:0] data);
    wren_in = 1'b1; wraddr_in = AW'(addr); wrdata_in = data;
    tick();
    wren_in = 1'b0; wraddr_in = 'x; wrdata_in = 'x;
  endtask

  task automatic shuffle(output int order [DEPTH]);
    for (int i = 0; i < DEPTH; i++) order[i] = i;
    for (int i = DEPTH - 1; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
  endtask

  initial begin
    int ord0 [DEPTH];
    int ord1 [DEPTH];
    rst = 1'b1; wren_in = 1'b0; wraddr_in = '0; wrdata_in = '0;
    rdaddr_in = '0;
    tick();
    rst = 1'b0;

    // Reset blocks writes but keeps contents.
    wr(3, 32'h1234_5678);
    rst = 1'b1; wren_in = 1'b1; wraddr_in = 8'd3; wrdata_in = 32'hDEAD_BEEF;
    rdaddr_in[0] = 8'd255;
    #1 chk("reset_oor_zero", 0, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0; wren_in = 1'b0;
    rdaddr_in[0] = 8'd3;
    #1 chk("reset_keeps_data", 0, 32'h1234_5678);
    wr(3, 32'h1111_1111);
    chk("write_after_reset", 0, 32'h1111_1111);

    // Random fill, then independent shuffled read sweeps.
    shuffle(ord0);
    for (int i = 0; i < DEPTH; i++) wr(ord0[i], $urandom);
    tick(); tick();
    shuffle(ord0);
    shuffle(ord1);
    for (int i = 0; i < DEPTH; i++) begin
      rdaddr_in[0] = AW'(ord0[i]);
      rdaddr_in[1] = AW'(ord1[i]);
      #1;
      chk("fill_p0", 0, model_read(ord0[i]));
      chk("fill_p1", 1, model_read(ord1[i]));
      tick();
    end

    // Same/different address and out-of-range table.
    wr(0, 32'hA5A5_A5A5);
    wr(216, 32'h5A5A_5A5A);
    wr(217, 32'hFFFF_FFFF);
    vecs[0] = '{"same_addr",  8'd216, 8'd216, 32'h5A5A_5A5A, 32'h5A5A_5A5A};
    vecs[1] = '{"split_addr", 8'd0,   8'd216, 32'hA5A5_A5A5, 32'h5A5A_5A5A};
    vecs[2] = '{"oor_both",   8'd217, 8'd255, 32'h0,         32'h0};
    vecs[3] = '{"oor_mixed",  8'd255, 8'd0,   32'h0,         32'hA5A5_A5A5};
    foreach (vecs[k]) begin
      rdaddr_in[1] = vecs[k].a1;
      rdaddr_in[0] = vecs[k].a0;
      #1;
      chk(vecs[k].name, 1, vecs[k].e1);
      chk(vecs[k].name, 0, vecs[k].e0);
      tick();
    end
    for (int a = 0; a < DEPTH; a++) begin
      rdaddr_in[0] = AW'(a);
      rdaddr_in[1] = AW'(DEPTH - 1 - a);
      #1;
      chk("oor_no_alias_p0", 0, model_read(a));
      chk("oor_no_alias_p1", 1, model_read(DEPTH - 1 - a));
    end

    // Read during write returns old data, new data next cycle.
    wr(10, 32'h1);
    rdaddr_in[0] = 8'd10;
    wren_in = 1'b1; wraddr_in = 8'd10; wrdata_in = 32'h2;
    #1 chk("rdw_old", 0, 32'h1);
    tick();
    wren_in = 1'b0;
    #1 chk("rdw_new", 0, 32'h2);

    // Back-to-back writes to one address.
    rdaddr_in[1] = 8'd5;
    wr(5, 32'h100);
    chk("b2b_first", 1, 32'h100);
    wr(5, 32'h200);
    chk("b2b_second", 1, 32'h200);

    // Random mixed traffic, including out-of-range and reset pulses.
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 15) == 0);
      wren_in   = $urandom_range(0, 1) == 1;
      wraddr_in = AW'($urandom_range(0, 255));
      wrdata_in = $urandom;
      if ($urandom_range(0, 3) == 0) rdaddr_in[0] = wraddr_in;
      else rdaddr_in[0] = AW'($urandom_range(0, 255));
      rdaddr_in[1] = AW'($urandom_range(0, 255));
      #1;
      chk("rand_p0", 0, model_read(int'(rdaddr_in[0])));
      chk("rand_p1", 1, model_read(int'(rdaddr_in[1])));
      tick();
    end
    rst = 1'b0; wren_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
